tile_band_ctrl: RTL
===================

Name: tile_band_ctrl

Overview:
- Controller and address sequencer for the 64x64 tile band on the 640x480 VGA display (rows 128..191).
- Holds a per-slot tile map with ten slots, each one of eight 64x64 tile images in the pixel ROM. A host edits a shadow copy of the map through a valid/ready port.
- Shadow changes commit only at a frame boundary after the host requests it.
- Adds a per-frame horizontal scroll and produces the registered ROM pixel_addr.

Parameters:
- BAND_TOP, 128, first display row of the band; band height is TILE_W.
- TILE_W, 64, tile width/height in pixels (power of two, fixed 6-bit row/col fields).
- NUM_SLOTS, 10, tile slots across the active width.
- H_ACTIVE, 640, active pixels per line; scroll modulus.
- NUM_TILES, 8, tile images in ROM (3-bit index).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- h_cnt  in  10  current pixel column.
- v_cnt  in  10  current pixel row.
- valid  in  1  display-active qualifier from the VGA timing block.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- wr_valid  in  1  host map write request.
- wr_ready  out  1  controller can accept a map write.
- wr_slot  in  4  slot to write, 0..NUM_SLOTS-1.
- wr_tile  in  3  tile index for that slot.
- commit_req  in  1  one-cycle pulse: request shadow->active commit.
- commit_ack  out  1  one-cycle pulse: commit done.
- scroll_en  in  1  apply scroll_step at each frame_tick.
- scroll_step  in  4  pixels of scroll per frame, 0..15.
- busy  out  1  commit pending or in progress.
- in_band  out  1  registered: pixel_addr refers to a band pixel.
- pixel_addr  out  17  registered ROM address.

Behaviour:
- Reset (rst=0, async):
  - pixel_addr=0, in_band=0, commit_ack=0, busy=0, wr_ready=0.
  - scroll=0; every shadow and active slot=0; state=RUN.
  - wr_ready rises the first clk edge after release.
- Address path, 1-cycle latency, registered:
  - Band pixel when valid=1, BAND_TOP<=v_cnt<BAND_TOP+TILE_W and h_cnt<H_ACTIVE.
  - x=(h_cnt+scroll) mod H_ACTIVE (11-bit sum, single conditional subtract).
  - slot=x>>6, col=x[5:0], row=(v_cnt-BAND_TOP)[5:0].
  - pixel_addr = active[slot]*4096 + row*64 + col, i.e. concatenation {2'b0,tile,row,col}.
  - in_band=1 for a band pixel. Otherwise pixel_addr=0 and in_band=0.
- State machine RUN / PEND / COMMIT:
  - RUN: commit_req -> PEND. A frame_tick in that same cycle is not used for the commit.
  - PEND: busy=1. Further commit_req is ignored. Next frame_tick -> COMMIT.
  - COMMIT, exactly one cycle: active<=shadow (all slots at once), wr_ready=0, busy=1. Then -> RUN with commit_ack=1 for that one cycle.
- Writes:
  - Accepted when wr_valid&wr_ready. wr_ready=1 in RUN and PEND, 0 in COMMIT and reset.
  - Accepted write updates shadow[wr_slot] at the edge.
  - wr_slot>=NUM_SLOTS: accepted and dropped, no state change.
  - A write accepted on the PEND cycle that sees frame_tick is included in the commit.
  - The active map never changes except in COMMIT, so a frame never shows a torn map.
- Scroll:
  - On frame_tick with scroll_en=1: scroll <= (scroll+scroll_step) mod H_ACTIVE.
  - Scroll updates are independent of commit state and coincide with the commit frame boundary.
- Reset mid-operation: pending commit discarded, no commit_ack, maps and scroll zeroed.

Test Plan:
- Reset released, valid=1, h=70, v=130 -> next cycle pixel_addr=134, in_band=1.
- Write slot1=tile3, pulse commit_req, no frame_tick for 100 cycles:
  - busy=1, h=70/v=130 still yields 134.
  - After frame_tick, COMMIT then commit_ack 1 cycle.
  - Same pixel then yields 12422.
- Band edges: v=127, v=192, h=640, or valid=0 -> pixel_addr=0, in_band=0. v=191, h=639 -> 9*64... tile0 addr 4095, in_band=1.
- Scroll wrap: scroll_en=1, step=15, 43 frame_ticks -> scroll=5. h=630, v=128 gives pixel_addr=59. h=635 gives 0 with in_band=1.
- wr_slot=12, wr_tile=7, then commit -> commit_ack pulses, all slots still 0; wr_ready=0 exactly on the COMMIT cycle.
- rst low while PEND -> busy=0, no commit_ack after release, slot1 reads back tile0 (addr 134 at h=70/v=130).

Source files
------------

// File: rtl/tile_band_ctrl.sv
// Tile band controller: shadow/active tile map with frame-boundary commit,
// per-frame horizontal scroll and a registered pixel ROM address for the band.
module tile_band_ctrl #(
  parameter int unsigned BAND_TOP  = 128,
  parameter int unsigned TILE_W    = 64,
  parameter int unsigned NUM_SLOTS = 10,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned NUM_TILES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        frame_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_slot,
  input  logic [2:0]  wr_tile,
  input  logic        commit_req,
  output logic        commit_ack,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_step,
  output logic        busy,
  output logic        in_band,
  output logic [16:0] pixel_addr
);

  localparam int unsigned TILE_IDX_W = $clog2(NUM_TILES);
  localparam int unsigned ROW_W      = $clog2(TILE_W);
  localparam int unsigned X_W        = 10;

  localparam logic [X_W-1:0] BAND_LO   = X_W'(BAND_TOP);
  localparam logic [X_W-1:0] BAND_HI   = X_W'(BAND_TOP + TILE_W);
  localparam logic [X_W-1:0] H_LIM     = X_W'(H_ACTIVE);
  localparam logic [X_W:0]   H_LIM_EXT = (X_W + 1)'(H_ACTIVE);
  localparam logic [3:0]     SLOT_LIM  = 4'(NUM_SLOTS);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TILE_IDX_W-1:0] shadow [NUM_SLOTS];
  logic [TILE_IDX_W-1:0] active [NUM_SLOTS];
  logic [X_W-1:0]        scroll;

  logic                  wr_fire;
  logic [X_W:0]          scroll_sum;
  logic [X_W-1:0]        scroll_wrap;
  logic [X_W:0]          x_sum;
  logic [X_W-1:0]        x_wrap;
  logic                  band;
  logic [TILE_IDX_W-1:0] tile_sel;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // Next-state logic; a frame_tick coinciding with commit_req only arms PEND
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (commit_req) state_nxt = ST_PEND;
      ST_PEND:   if (frame_tick) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Handshake and status outputs, registered from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      commit_ack <= 1'b0;
    end else begin
      wr_ready   <= (state_nxt != ST_COMMIT);
      busy       <= (state_nxt != ST_RUN);
      commit_ack <= (state == ST_COMMIT);
    end
  end

  assign wr_fire = wr_valid & wr_ready;

  // Shadow edits from the host; active map only changes on the commit cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_fire && (wr_slot < SLOT_LIM)) shadow[wr_slot] <= wr_tile;
      if (state == ST_COMMIT) active <= shadow;
    end
  end

  assign scroll_sum  = {1'b0, scroll} + (X_W + 1)'(scroll_step);
  assign scroll_wrap = (scroll_sum >= H_LIM_EXT) ? X_W'(scroll_sum - H_LIM_EXT)
                                                 : scroll_sum[X_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         scroll <= '0;
    else if (frame_tick && scroll_en) scroll <= scroll_wrap;
  end

  // Scrolled column; both operands are below H_ACTIVE so one subtract suffices
  assign x_sum  = {1'b0, h_cnt} + {1'b0, scroll};
  assign x_wrap = (x_sum >= H_LIM_EXT) ? X_W'(x_sum - H_LIM_EXT) : x_sum[X_W-1:0];

  assign band     = valid && (v_cnt >= BAND_LO) && (v_cnt < BAND_HI) && (h_cnt < H_LIM);
  assign tile_sel = active[x_wrap[X_W-1:ROW_W]];

  // BAND_TOP is tile-aligned, so the band row is the low bits of v_cnt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_addr <= '0;
      in_band    <= 1'b0;
    end else begin
      pixel_addr <= band ? {2'b00, tile_sel, v_cnt[ROW_W-1:0], x_wrap[ROW_W-1:0]} : '0;
      in_band    <= band;
    end
  end

endmodule
